dual_edge_detector: RTL and testbench



---
 rtl/dual_edge_detector.sv | 70 +++++++
 tb/tb_dual_edge_detector.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dual_edge_detector.sv
// Dual edge detector: one-cycle pulse on out for every rising and falling
// transition of in. Optional synchroniser stages on in; 4-state Moore FSM
// whose pulse is decoded from state and held in a flop.
module dual_edge_detector #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    RISE = 2'd1,
    ONE  = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   s;

  // Sampled input: direct, or via a SYNC_STAGES-deep reset-to-zero shift register
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift in toward the FSM one stage per clock
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= in;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Next-state decode; any unexpected encoding falls back to ZERO
  always_comb begin
    state_nxt = ZERO;
    case (state)
      ZERO:    state_nxt = s ? RISE : ZERO;
      RISE:    state_nxt = s ? ONE  : FALL;
      ONE:     state_nxt = s ? ONE  : FALL;
      FALL:    state_nxt = s ? RISE : ZERO;
      default: state_nxt = ZERO;
    endcase
  end

  // State register plus registered Moore output (high while in RISE or FALL)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ZERO;
      out   <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= (state_nxt == RISE) || (state_nxt == FALL);
    end
  end

endmodule

// File: tb/tb_dual_edge_detector.sv
// Bench for dual_edge_detector: directed test-plan sequences followed by
// random traffic, comparing two instances (0 and 2 sync stages) against a
// model that pulses whenever the delayed sample differs from the previous one.
module tb_dual_edge_detector;

  logic clk;
  logic rst;
  logic in;
  logic out0;
  logic out2;

  int unsigned vectors;
  int unsigned miscompares;

  // Model state: previous sample for each instance and a 2-deep delay queue
  logic prev0;
  logic prev2;
  logic dly2[$];

  dual_edge_detector #(.SYNC_STAGES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out0)
  );

  dual_edge_detector #(.SYNC_STAGES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive at negedge (optionally with a short unsampled glitch),
  // advance the model across the posedge, then compare both instances.
  task automatic cycle(input logic r, input logic v, input logic glitch, input string tag);
    logic s0;
    logic s2;
    logic exp0;
    logic exp2;
    @(negedge clk);
    rst = r;
    in  = v;
    if (glitch) begin
      #1 in = ~v;
      #1 in = v;
    end
    @(posedge clk);
    #1;
    if (r) begin
      prev0 = 1'b0;
      prev2 = 1'b0;
      dly2  = '{1'b0, 1'b0};
      exp0  = 1'b0;
      exp2  = 1'b0;
    end else begin
      s0 = v;
      dly2.push_back(v);
      s2 = dly2.pop_front();
      exp0  = s0 ^ prev0;
      exp2  = s2 ^ prev2;
      prev0 = s0;
      prev2 = s2;
    end
    check({tag, "/s0"}, out0, exp0);
    check({tag, "/s2"}, out2, exp2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev0       = 1'b0;
    prev2       = 1'b0;
    dly2        = '{1'b0, 1'b0};
    rst         = 1'b1;
    in          = 1'b0;

    // Reset held with in low, then released with in low
    repeat (2) cycle(1'b1, 1'b0, 1'b0, "reset");
    repeat (2) cycle(1'b0, 1'b0, 1'b0, "idle");

    // Rising edge held, then falling edge held
    repeat (4) cycle(1'b0, 1'b1, 1'b0, "rise");
    repeat (4) cycle(1'b0, 1'b0, 1'b0, "fall");

    // Single-cycle high pulse gives rise then fall back to back
    cycle(1'b0, 1'b1, 1'b0, "narrow");
    repeat (4) cycle(1'b0, 1'b0, 1'b0, "narrow_tail");

    // Reset asserted while a pulse is on out, released with in high
    cycle(1'b0, 1'b1, 1'b0, "mid_rise");
    cycle(1'b1, 1'b1, 1'b0, "mid_rst");
    repeat (5) cycle(1'b0, 1'b1, 1'b0, "post_rst");
    repeat (4) cycle(1'b0, 1'b0, 1'b0, "post_rst_low");

    // Sub-cycle glitches that are never sampled
    repeat (3) cycle(1'b0, 1'b0, 1'b1, "glitch_low");
    repeat (3) cycle(1'b0, 1'b1, 1'b1, "glitch_high");

    // Random level traffic with occasional resets and glitches
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
